// File: rtl/mlp_load_sequencer.sv
// mlp_load_sequencer
//   Streams input and weight words from a word-addressed staging SRAM
//   (one-cycle read latency) onto the MLP accelerator load port. Layer 0
//   interleaves eight input beats with eight weight beats per row. Layers
//   1..NUM_LAYERS-1 carry weight beats only. The block then collects 128
//   result beats into a result buffer and signals done or a timeout error.
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   start_i               : start pulse, accepted only in IDLE
//   busy_o, done_o        : run in progress / one-cycle completion pulse
//   error_o               : sticky timeout flag, cleared by the next start
//   mem_rd_en_o/addr_o    : staging SRAM read strobe and word address
//   mem_rdata_i           : SRAM read data, valid the cycle after the strobe
//   load_*                : accelerator load bus (beat valid, payload, fields)
//   result_valid_i/payload: accelerator result beats
//   res_wr_*              : result buffer write port
module mlp_load_sequencer #(
  parameter int NUM_LAYERS = 8,
  parameter int ROWS       = 16,
  parameter int BEATS      = 8,
  parameter int ADDR_W     = 11,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              load_en_o,
  output logic [31:0]       load_payload_o,
  output logic              load_type_o,
  output logic [3:0]        input_load_number_o,
  output logic [2:0]        layer_number_o,
  output logic [2:0]        weight_number_o,
  input  logic              result_valid_i,
  input  logic [31:0]       result_payload_i,
  output logic              res_wr_en_o,
  output logic [6:0]        res_wr_addr_o,
  output logic [31:0]       res_wr_data_o
);
  localparam int MAT_WORDS = ROWS * BEATS;
  localparam int RES_BEATS = 128;
  localparam int RES_W     = $clog2(RES_BEATS + 1);
  localparam int TMO_W     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_L0, S_LOAD_LN, S_DRAIN, S_WAIT_RES, S_DONE, S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       row_q, beat_q;
  logic [2:0]       layer_q;
  logic [RES_W-1:0] res_cnt_q;
  logic [TMO_W-1:0] tmo_q;
  logic             error_q;

  logic start_acc, l0_last, ln_row_end, ln_last, res_full, cap_en, capture;

  logic              rd_en_p0, type_p0;
  logic [ADDR_W-1:0] addr_p0, row_base_p0;
  logic [2:0]        wn_p0;

  logic        vld_p1, type_p1;
  logic [3:0]  row_p1;
  logic [2:0]  layer_p1, wn_p1;
  logic        res_vld_p1;
  logic [6:0]  res_addr_p1;
  logic [31:0] res_data_p1;

  assign start_acc  = (state_q == S_IDLE) && start_i;
  assign l0_last    = (row_q == 4'(ROWS - 1)) && (beat_q == 4'(2 * BEATS - 1));
  assign ln_row_end = (beat_q == 4'(BEATS - 1));
  assign ln_last    = ln_row_end && (row_q == 4'(ROWS - 1)) &&
                      (layer_q == 3'(NUM_LAYERS - 1));
  assign res_full   = (res_cnt_q == RES_W'(RES_BEATS));
  // Once 128 results are in, later beats are dropped rather than overflowing.
  assign capture    = cap_en && result_valid_i && !res_full;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_i) state_d = S_LOAD_L0;
      S_LOAD_L0:  if (l0_last) state_d = (NUM_LAYERS == 1) ? S_DRAIN : S_LOAD_LN;
      S_LOAD_LN:  if (ln_last) state_d = S_DRAIN;
      // Results may all have arrived during the load stream; skip waiting then.
      S_DRAIN:    state_d = res_full ? S_DONE : S_WAIT_RES;
      S_WAIT_RES: begin
        if (res_full) state_d = S_DONE;
        else if (!result_valid_i && (tmo_q == TMO_W'(TIMEOUT - 1))) state_d = S_ERR;
      end
      S_DONE:     state_d = S_IDLE;
      S_ERR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Stage p0: read request and beat fields derived from the counters.
  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    cap_en      = 1'b0;
    rd_en_p0    = 1'b0;
    type_p0     = 1'b0;
    wn_p0       = '0;
    addr_p0     = '0;
    row_base_p0 = ADDR_W'(row_q) * ADDR_W'(BEATS);
    case (state_q)
      S_LOAD_L0: begin
        busy_o   = 1'b1;
        cap_en   = 1'b1;
        rd_en_p0 = 1'b1;
        if (beat_q < 4'(BEATS)) begin
          type_p0 = 1'b1;
          addr_p0 = row_base_p0 + ADDR_W'(beat_q);
        end else begin
          wn_p0   = 3'(beat_q - 4'(BEATS));
          addr_p0 = ADDR_W'(MAT_WORDS) + row_base_p0 + ADDR_W'(wn_p0);
        end
      end
      S_LOAD_LN: begin
        busy_o   = 1'b1;
        cap_en   = 1'b1;
        rd_en_p0 = 1'b1;
        wn_p0    = beat_q[2:0];
        addr_p0  = ADDR_W'(MAT_WORDS) * (ADDR_W'(layer_q) + ADDR_W'(1)) +
                   row_base_p0 + ADDR_W'(beat_q);
      end
      S_DRAIN, S_WAIT_RES: begin
        busy_o = 1'b1;
        cap_en = 1'b1;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign mem_rd_en_o = rd_en_p0;
  assign mem_addr_o  = addr_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q     <= '0;
      beat_q    <= '0;
      layer_q   <= '0;
      res_cnt_q <= '0;
      tmo_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      if (start_acc) begin
        row_q     <= '0;
        beat_q    <= '0;
        layer_q   <= '0;
        res_cnt_q <= '0;
        error_q   <= 1'b0;
      end else begin
        case (state_q)
          S_LOAD_L0: begin
            if (beat_q == 4'(2 * BEATS - 1)) begin
              beat_q <= '0;
              if (row_q == 4'(ROWS - 1)) begin
                row_q   <= '0;
                layer_q <= 3'd1;
              end else begin
                row_q <= row_q + 4'd1;
              end
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
          S_LOAD_LN: begin
            if (ln_row_end) begin
              beat_q <= '0;
              if (row_q == 4'(ROWS - 1)) begin
                row_q   <= '0;
                layer_q <= layer_q + 3'd1;
              end else begin
                row_q <= row_q + 4'd1;
              end
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
          default: ;
        endcase
        if (capture) res_cnt_q <= res_cnt_q + RES_W'(1);
        if ((state_q == S_WAIT_RES) && (state_d == S_ERR)) error_q <= 1'b1;
      end
      // Idle-cycle counter: only meaningful while waiting on results.
      if ((state_q == S_WAIT_RES) && !result_valid_i) tmo_q <= tmo_q + TMO_W'(1);
      else                                             tmo_q <= '0;
    end
  end

  // Stage p1: load bus aligned with SRAM read data, result write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      res_vld_p1 <= 1'b0;
    end else begin
      vld_p1     <= rd_en_p0;
      res_vld_p1 <= capture;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en_p0) begin
      type_p1  <= type_p0;
      row_p1   <= row_q;
      layer_p1 <= layer_q;
      wn_p1    <= wn_p0;
    end
    if (capture) begin
      res_addr_p1 <= 7'(res_cnt_q);
      res_data_p1 <= result_payload_i;
    end
  end

  // Field registers carry no reset; gating by the valids keeps outputs at zero.
  assign load_en_o           = vld_p1;
  assign load_payload_o      = vld_p1 ? mem_rdata_i : '0;
  assign load_type_o         = vld_p1 & type_p1;
  assign input_load_number_o = vld_p1 ? row_p1 : '0;
  assign layer_number_o      = vld_p1 ? layer_p1 : '0;
  assign weight_number_o     = vld_p1 ? wn_p1 : '0;
  assign res_wr_en_o         = res_vld_p1;
  assign res_wr_addr_o       = res_vld_p1 ? res_addr_p1 : '0;
  assign res_wr_data_o       = res_vld_p1 ? res_data_p1 : '0;
  assign error_o             = error_q;
endmodule
